// File: rtl/ifetch_if.sv
// Fetch unit bus: instruction-memory handshake, decoder-facing instruction
// register and the decoder's next-PC controls.
interface ifetch_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] instr;
    logic            instr_valid;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] link_pc;
    logic            stall;
    logic [1:0]      PC_MUX_Select;
    logic [3:0]      Bf;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] retired_count;

    // Fetch unit side
    modport master (
        input  imem_ack, imem_rdata, stall, PC_MUX_Select, Bf, rs_data, rt_data,
        output imem_req, imem_addr, instr, instr_valid, instr_pc, link_pc, retired_count
    );

    // Memory / decoder side
    modport slave (
        output imem_ack, imem_rdata, stall, PC_MUX_Select, Bf, rs_data, rt_data,
        input  imem_req, imem_addr, instr, instr_valid, instr_pc, link_pc, retired_count
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: requests one word at pc, holds it for the decoder
// until consumed, then advances pc by the decoder's seq/branch/jump select.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst,
    ifetch_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] retired_q, retired_d;
    logic            req_q, req_d;
    logic            valid_q, valid_d;

    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jmp_pc;
    logic [XLEN-1:0] next_pc;
    logic            taken;

    // Next-PC selection for the held instruction; only used when it is consumed
    always_comb begin
        seq_pc  = instr_pc_q + 32'd4;
        br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        jmp_pc  = {seq_pc[31:28], instr_q[25:0], 2'b00};
        taken   = ((bus.Bf == 4'b0001) && (bus.rs_data == bus.rt_data)) ||
                  ((bus.Bf == 4'b0010) && (bus.rs_data != bus.rt_data));
        next_pc = seq_pc;
        case (bus.PC_MUX_Select)
            2'b01:   next_pc = taken ? (seq_pc + br_off) : seq_pc;
            2'b10:   next_pc = jmp_pc;
            default: next_pc = seq_pc;
        endcase
    end

    // FETCH waits for the memory ack, VALID waits for the decoder to take the word
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        retired_d  = retired_q;
        req_d      = req_q;
        valid_d    = valid_q;
        case (state_q)
            FETCH: begin
                if (bus.imem_ack) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    state_d    = VALID;
                    req_d      = 1'b0;
                    valid_d    = 1'b1;
                end
            end
            VALID: begin
                if (!bus.stall) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                    req_d     = 1'b1;
                    valid_d   = 1'b0;
                end
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            instr_q    <= '0;
            instr_pc_q <= '0;
            retired_q  <= '0;
            req_q      <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            retired_q  <= retired_d;
            req_q      <= req_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.imem_req      = req_q;
    assign bus.imem_addr     = pc_q;
    assign bus.instr         = instr_q;
    assign bus.instr_valid   = valid_q;
    assign bus.instr_pc      = instr_pc_q;
    assign bus.link_pc       = instr_pc_q + 32'd4;
    assign bus.retired_count = retired_q;
endmodule
